// File: rtl/float_pack.sv
// Shared types for the float coprocessor sequencer.
// Opcodes, the quiet-NaN return value and the sequencer states.
package float_pack;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

endpackage

// File: rtl/copro_timeout.sv
// Wait-phase cycle counter with clear, enable and terminal count.
// Saturates at TIMEOUT-1 so tc stays asserted until cleared.
module copro_timeout #(
  parameter int TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [W-1:0] count;

  assign tc = (count == W'(TIMEOUT - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/copro_seq.sv
// Sequences CPU custom float instructions onto a shared operator.
// Issues one start, waits for done or timeout, strobes completion.
module copro_seq
  import float_pack::*;
#(
  parameter int TIMEOUT = 64,
  parameter int OPC_W   = 11
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             user_valid_i,
  input  logic [OPC_W-1:0] user_opcode_i,
  input  logic [31:0]      user_operand_0_i,
  input  logic [31:0]      user_operand_1_i,
  output logic [31:0]      user_result_o,
  output logic             user_complete_o,
  output logic             op_start_o,
  output logic [1:0]       op_code_o,
  output logic [31:0]      op_a_o,
  output logic [31:0]      op_b_o,
  input  logic [31:0]      op_result_i,
  input  logic             op_done_i,
  output logic             err_o,
  input  logic             err_clr_i
);

  state_t state;
  logic   legal;
  logic   tc;

  assign legal = ((user_opcode_i >> 2) == '0);

  copro_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .clear(state == S_ISSUE),
    .en   (state == S_WAIT),
    .tc   (tc)
  );

  // err set assignments come after the clear so a set wins
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state           <= S_IDLE;
      user_result_o   <= '0;
      user_complete_o <= 1'b0;
      op_start_o      <= 1'b0;
      op_code_o       <= '0;
      op_a_o          <= '0;
      op_b_o          <= '0;
      err_o           <= 1'b0;
    end else begin
      op_start_o      <= 1'b0;
      user_complete_o <= 1'b0;
      if (err_clr_i) err_o <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (user_valid_i) begin
            if (legal) begin
              op_a_o     <= user_operand_0_i;
              op_b_o     <= user_operand_1_i;
              op_code_o  <= user_opcode_i[1:0];
              op_start_o <= 1'b1;
              state      <= S_ISSUE;
            end else begin
              user_result_o   <= '0;
              err_o           <= 1'b1;
              user_complete_o <= 1'b1;
              state           <= S_DONE;
            end
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (op_done_i) begin
            user_result_o   <= op_result_i;
            user_complete_o <= 1'b1;
            state           <= S_DONE;
          end else if (tc) begin
            user_result_o   <= QNAN;
            err_o           <= 1'b1;
            user_complete_o <= 1'b1;
            state           <= S_DONE;
          end
        end
        S_DONE: state <= S_DRAIN;
        S_DRAIN: begin
          if (!user_valid_i) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_copro_seq.sv
// Scoreboard bench for copro_seq with a scripted float-operator stub.
// Cycle 0 is the cycle in which user_valid_i is first sampled.
module tb_copro_seq;
  import float_pack::*;

  localparam int TIMEOUT = 8;
  localparam int OPC_W   = 11;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             user_valid_i;
  logic [OPC_W-1:0] user_opcode_i;
  logic [31:0]      user_operand_0_i;
  logic [31:0]      user_operand_1_i;
  logic [31:0]      user_result_o;
  logic             user_complete_o;
  logic             op_start_o;
  logic [1:0]       op_code_o;
  logic [31:0]      op_a_o;
  logic [31:0]      op_b_o;
  logic [31:0]      op_result_i;
  logic             op_done_i;
  logic             err_o;
  logic             err_clr_i;

  copro_seq #(
    .TIMEOUT(TIMEOUT),
    .OPC_W  (OPC_W)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .user_valid_i    (user_valid_i),
    .user_opcode_i   (user_opcode_i),
    .user_operand_0_i(user_operand_0_i),
    .user_operand_1_i(user_operand_1_i),
    .user_result_o   (user_result_o),
    .user_complete_o (user_complete_o),
    .op_start_o      (op_start_o),
    .op_code_o       (op_code_o),
    .op_a_o          (op_a_o),
    .op_b_o          (op_b_o),
    .op_result_i     (op_result_i),
    .op_done_i       (op_done_i),
    .err_o           (err_o),
    .err_clr_i       (err_clr_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] res;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  // Drives one request and plays the operator stub; returns observations.
  task automatic drive_op(
    input  logic [OPC_W-1:0] opc,
    input  logic [31:0]      a,
    input  logic [31:0]      b,
    input  int               done_cyc,
    input  logic [31:0]      stub,
    input  int               hold,
    input  int               max_cyc,
    input  logic             clr0,
    output int               n_start,
    output int               start_cyc,
    output int               n_cmp,
    output int               cmp_cyc,
    output logic [31:0]      res,
    output logic             err
  );
    n_start = 0; start_cyc = -1;
    n_cmp = 0; cmp_cyc = -1;
    res = 'x; err = 1'bx;
    user_valid_i = 1'b1;
    user_opcode_i = opc;
    user_operand_0_i = a;
    user_operand_1_i = b;
    err_clr_i = clr0;
    for (int c = 1; c <= max_cyc; c++) begin
      step;
      err_clr_i = 1'b0;
      user_valid_i = (c <= hold);
      op_done_i = (c == done_cyc);
      op_result_i = (c == done_cyc) ? stub : 32'hDEAD_BEEF;
      if (op_start_o) begin
        n_start++;
        start_cyc = c;
      end
      if (user_complete_o) begin
        n_cmp++;
        cmp_cyc = c;
        res = user_result_o;
        err = err_o;
      end
    end
    user_valid_i = 1'b0;
    op_done_i = 1'b0;
    step;
    step;
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    user_valid_i = 1'b0;
    user_opcode_i = '0;
    user_operand_0_i = '0;
    user_operand_1_i = '0;
    op_result_i = '0;
    op_done_i = 1'b0;
    err_clr_i = 1'b0;
    step;
    step;
    vectors++;
    if ({user_result_o, user_complete_o, op_start_o, op_code_o,
         op_a_o, op_b_o, err_o} !== 101'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h want 0",
        {user_result_o, user_complete_o, op_start_o, op_code_o,
         op_a_o, op_b_o, err_o});
    end
    rst_i = 1'b0;
    step;
  endtask

  task automatic test_add;
    exp_t e;
    int ns, sc, nc, cc;
    logic [31:0] r;
    logic er;
    sb.push_back('{32'h4040_0000, 1'b0, 3});
    drive_op(11'd0, 32'h3F80_0000, 32'h4000_0000, 2, 32'h4040_0000,
      0, 6, 1'b0, ns, sc, nc, cc, r, er);
    e = sb.pop_front();
    vectors++;
    if (nc !== 1 || cc !== e.cyc) begin
      miscompares++;
      $display("FAIL add_complete: got n=%0d cyc=%0d want n=1 cyc=%0d",
        nc, cc, e.cyc);
    end
    vectors++;
    if (r !== e.res || er !== e.err) begin
      miscompares++;
      $display("FAIL add_result: got %h err=%b want %h err=%b",
        r, er, e.res, e.err);
    end
    vectors++;
    if (ns !== 1 || sc !== 1) begin
      miscompares++;
      $display("FAIL add_start: got n=%0d cyc=%0d want n=1 cyc=1", ns, sc);
    end
    vectors++;
    if ({op_a_o, op_b_o, op_code_o} !== {32'h3F80_0000, 32'h4000_0000, 2'd0}) begin
      miscompares++;
      $display("FAIL add_operands: got %h %h %0d want 3f800000 40000000 0",
        op_a_o, op_b_o, op_code_o);
    end
  endtask

  task automatic test_idle_done;
    int n = 0;
    op_done_i = 1'b1;
    op_result_i = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      step;
      if (user_complete_o) n++;
    end
    op_done_i = 1'b0;
    step;
    vectors++;
    if (n !== 0 || user_result_o !== 32'h4040_0000) begin
      miscompares++;
      $display("FAIL idle_done: got cmp=%0d res=%h want cmp=0 res=40400000",
        n, user_result_o);
    end
  endtask

  task automatic test_timeout;
    exp_t e;
    int ns, sc, nc, cc;
    logic [31:0] r;
    logic er;
    sb.push_back('{QNAN, 1'b1, 10});
    drive_op(11'd2, 32'h4120_0000, 32'h3F00_0000, 0, 32'h0,
      0, 13, 1'b0, ns, sc, nc, cc, r, er);
    e = sb.pop_front();
    vectors++;
    if (nc !== 1 || cc !== e.cyc) begin
      miscompares++;
      $display("FAIL timeout_complete: got n=%0d cyc=%0d want n=1 cyc=%0d",
        nc, cc, e.cyc);
    end
    vectors++;
    if (r !== e.res || er !== e.err) begin
      miscompares++;
      $display("FAIL timeout_result: got %h err=%b want %h err=%b",
        r, er, e.res, e.err);
    end
    vectors++;
    if (op_code_o !== 2'd2 || ns !== 1) begin
      miscompares++;
      $display("FAIL timeout_issue: got code=%0d starts=%0d want 2 1",
        op_code_o, ns);
    end
    err_clr_i = 1'b1;
    step;
    err_clr_i = 1'b0;
    vectors++;
    if (err_o !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_clear: got err=%b want 0", err_o);
    end
  endtask

  task automatic test_terminal_done;
    exp_t e;
    int ns, sc, nc, cc;
    logic [31:0] r;
    logic er;
    sb.push_back('{32'h3E80_0000, 1'b0, 10});
    drive_op(11'd3, 32'h3F80_0000, 32'h4080_0000, 9, 32'h3E80_0000,
      0, 13, 1'b0, ns, sc, nc, cc, r, er);
    e = sb.pop_front();
    vectors++;
    if (nc !== 1 || cc !== e.cyc || r !== e.res || er !== e.err) begin
      miscompares++;
      $display("FAIL terminal_done: got n=%0d cyc=%0d res=%h err=%b want n=1 cyc=%0d res=%h err=%b",
        nc, cc, r, er, e.cyc, e.res, e.err);
    end
  endtask

  task automatic test_illegal;
    exp_t e;
    int ns, sc, nc, cc;
    logic [31:0] r;
    logic er;
    sb.push_back('{32'h0, 1'b1, 1});
    drive_op(11'd5, 32'h1111_1111, 32'h2222_2222, 0, 32'h0,
      0, 4, 1'b0, ns, sc, nc, cc, r, er);
    e = sb.pop_front();
    vectors++;
    if (nc !== 1 || cc !== e.cyc || r !== e.res || er !== e.err) begin
      miscompares++;
      $display("FAIL illegal_complete: got n=%0d cyc=%0d res=%h err=%b want n=1 cyc=%0d res=%h err=%b",
        nc, cc, r, er, e.cyc, e.res, e.err);
    end
    vectors++;
    if (ns !== 0) begin
      miscompares++;
      $display("FAIL illegal_start: got starts=%0d want 0", ns);
    end
    err_clr_i = 1'b1;
    step;
    err_clr_i = 1'b0;
    vectors++;
    if (err_o !== 1'b0) begin
      miscompares++;
      $display("FAIL illegal_clear: got err=%b want 0", err_o);
    end
    sb.push_back('{32'h0, 1'b1, 1});
    drive_op(11'h400, 32'h0, 32'h0, 0, 32'h0,
      0, 4, 1'b1, ns, sc, nc, cc, r, er);
    e = sb.pop_front();
    vectors++;
    if (nc !== 1 || cc !== e.cyc || er !== e.err || ns !== 0) begin
      miscompares++;
      $display("FAIL set_wins: got n=%0d cyc=%0d err=%b starts=%0d want n=1 cyc=%0d err=%b starts=0",
        nc, cc, er, ns, e.cyc, e.err);
    end
    err_clr_i = 1'b1;
    step;
    err_clr_i = 1'b0;
  endtask

  task automatic test_valid_drop;
    exp_t e;
    int ns, sc, nc, cc;
    logic [31:0] r;
    logic er;
    sb.push_back('{32'hC000_0000, 1'b0, 6});
    drive_op(11'd1, 32'h3F80_0000, 32'h4040_0000, 5, 32'hC000_0000,
      0, 9, 1'b0, ns, sc, nc, cc, r, er);
    e = sb.pop_front();
    vectors++;
    if (nc !== 1 || cc !== e.cyc || r !== e.res || er !== e.err) begin
      miscompares++;
      $display("FAIL valid_drop: got n=%0d cyc=%0d res=%h err=%b want n=1 cyc=%0d res=%h err=%b",
        nc, cc, r, er, e.cyc, e.res, e.err);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int ns, sc, nc, cc;
    logic [31:0] r;
    logic er;
    sb.push_back('{32'h4110_0000, 1'b0, 3});
    drive_op(11'd2, 32'h4040_0000, 32'h4040_0000, 2, 32'h4110_0000,
      22, 25, 1'b0, ns, sc, nc, cc, r, er);
    e = sb.pop_front();
    vectors++;
    if (ns !== 1 || nc !== 1 || cc !== e.cyc || r !== e.res) begin
      miscompares++;
      $display("FAIL held_valid: got starts=%0d n=%0d cyc=%0d res=%h want 1 1 %0d %h",
        ns, nc, cc, r, e.cyc, e.res);
    end
    sb.push_back('{32'h40A0_0000, 1'b0, 5});
    drive_op(11'd0, 32'h4000_0000, 32'h4040_0000, 4, 32'h40A0_0000,
      0, 8, 1'b0, ns, sc, nc, cc, r, er);
    e = sb.pop_front();
    vectors++;
    if (ns !== 1 || sc !== 1 || nc !== 1 || cc !== e.cyc || r !== e.res) begin
      miscompares++;
      $display("FAIL reaccept: got starts=%0d scyc=%0d n=%0d cyc=%0d res=%h want 1 1 1 %0d %h",
        ns, sc, nc, cc, r, e.cyc, e.res);
    end
  endtask

  task automatic test_reset_wait;
    int n = 0;
    user_valid_i = 1'b1;
    user_opcode_i = 11'd3;
    user_operand_0_i = 32'h4248_0000;
    user_operand_1_i = 32'h4000_0000;
    step;
    user_valid_i = 1'b0;
    for (int c = 2; c <= 5; c++) step;
    rst_i = 1'b1;
    #1;
    vectors++;
    if ({user_result_o, user_complete_o, op_start_o, op_code_o,
         op_a_o, op_b_o, err_o} !== 101'd0) begin
      miscompares++;
      $display("FAIL reset_async: got %h want 0",
        {user_result_o, user_complete_o, op_start_o, op_code_o,
         op_a_o, op_b_o, err_o});
    end
    step;
    rst_i = 1'b0;
    op_done_i = 1'b1;
    op_result_i = 32'h1234_5678;
    for (int i = 0; i < 4; i++) begin
      step;
      op_done_i = 1'b0;
      if (user_complete_o) n++;
    end
    vectors++;
    if (n !== 0 || dut.state !== S_IDLE || user_result_o !== 32'h0 ||
        err_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_wait: got cmp=%0d state=%0d res=%h err=%b want 0 0 0 0",
        n, dut.state, user_result_o, err_o);
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_idle_done;
    test_timeout;
    test_terminal_done;
    test_illegal;
    test_valid_drop;
    test_back_to_back;
    test_reset_wait;
    $display("== %0d vectors applied, %0d miscompares ==",
      vectors, miscompares);
    $finish;
  end

endmodule
